// File: rtl/sid_waveform_mixer.sv
// SID voice waveform selector: ANDs the selected waveform components into the 12-bit DAC input.
// When no waveform is selected, it holds the floating DAC value and then fades it out.
package sid;
  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  localparam int PHI1 = 0;
  localparam int PHI2 = 1;
  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic [3:0]  selector;
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
  } waveform_i_t;
endpackage

module sid_waveform_mixer
  import sid::*;
#(
  parameter logic [13:0] FLOAT_TTL_6581 = 14'd54,
  parameter logic [13:0] FLOAT_TTL_8580 = 14'd800
) (
  input  logic        clk,
  input  logic        res,
  input  logic        tick_ms,
  input  model_e      model,
  input  phase_t      phase,
  input  waveform_i_t wave,
  output logic [11:0] out,
  output logic [7:0]  noise_wb
);

  logic [11:0] combined;
  logic [13:0] ttl;
  logic [13:0] age;
  logic [13:0] age_inc;
  logic        fading;
  logic        noise_combo;
  logic        unused_phase;

  always_comb begin
    combined = 12'hfff;
    if (wave.selector[0]) combined = combined & {wave.saw_tri[10:0], 1'b0};
    if (wave.selector[1]) combined = combined & wave.saw_tri;
    if (wave.selector[2]) combined = combined & {12{wave.pulse}};
    if (wave.selector[3]) combined = combined & {wave.noise, 4'b0000};
  end

  assign ttl          = (model == MOS8580) ? FLOAT_TTL_8580 : FLOAT_TTL_6581;
  assign age_inc      = age + 14'd1;
  assign noise_combo  = wave.selector[3] & (|wave.selector[2:0]);
  assign unused_phase = phase[PHI1];

  // The >= comparisons let a model switch to a shorter TTL start the fade on the next tick.
  always_ff @(posedge clk) begin
    if (res) begin
      out      <= 12'h000;
      noise_wb <= 8'hff;
      age      <= 14'd0;
      fading   <= 1'b0;
    end else if (phase[PHI2]) begin
      noise_wb <= noise_combo ? combined[11:4] : 8'hff;
      if (wave.selector != 4'b0000) begin
        out    <= combined;
        age    <= 14'd0;
        fading <= 1'b0;
      end else if (tick_ms) begin
        if (fading) begin
          out <= out & (out >> 1);
        end else if (age >= ttl) begin
          fading <= 1'b1;
        end else begin
          age    <= age_inc;
          fading <= (age_inc >= ttl);
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Self-checking bench for sid_waveform_mixer: directed scenarios plus randomized
// stimulus compared against a behavioural float/fade model.
module tb_sid_waveform_mixer;
  import sid::*;

  logic        clk = 1'b0;
  logic        res;
  logic        tick_ms;
  model_e      model;
  phase_t      phase;
  waveform_i_t wave;
  logic [11:0] out;
  logic [7:0]  noise_wb;

  logic [3:0]  sel;
  logic [7:0]  nz;
  logic        pl;
  logic [11:0] st;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] m_out;
  logic [7:0]  m_wb;
  int          m_ms_floating;
  bit          m_fading;

  assign wave = {sel, nz, pl, st};

  sid_waveform_mixer dut (
    .clk      (clk),
    .res      (res),
    .tick_ms  (tick_ms),
    .model    (model),
    .phase    (phase),
    .wave     (wave),
    .out      (out),
    .noise_wb (noise_wb)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_combined();
    logic [11:0] comp [4];
    logic [11:0] r;
    comp[0] = {st[10:0], 1'b0};
    comp[1] = st;
    comp[2] = pl ? 12'hfff : 12'h000;
    comp[3] = {nz, 4'h0};
    r = 12'hfff;
    for (int i = 0; i < 4; i++) if (sel[i]) r = r & comp[i];
    return r;
  endfunction

  function automatic int ref_ttl();
    return (model == MOS8580) ? 800 : 54;
  endfunction

  // One clock with the given controls; the model advances on the same edge.
  task automatic drive(input bit r, input bit p2, input bit tk);
    logic [11:0] c;
    res = r;
    tick_ms = tk;
    phase = '0;
    phase[PHI2] = p2;
    @(posedge clk);
    c = ref_combined();
    if (r) begin
      m_out = 12'h000; m_wb = 8'hff; m_ms_floating = 0; m_fading = 0;
    end else if (p2) begin
      m_wb = (sel[3] && sel[2:0] != 3'b000) ? c[11:4] : 8'hff;
      if (sel != 4'b0000) begin
        m_out = c; m_ms_floating = 0; m_fading = 0;
      end else if (tk) begin
        if (m_fading) m_out = m_out & (m_out >> 1);
        else if (m_ms_floating >= ref_ttl()) m_fading = 1;
        else begin
          m_ms_floating++;
          if (m_ms_floating >= ref_ttl()) m_fading = 1;
        end
      end
    end
    #1;
  endtask

  task automatic set_wave(input logic [3:0] s, input logic [11:0] t, input logic p, input logic [7:0] n);
    sel = s; st = t; pl = p; nz = n;
  endtask

  // A PHI2 tick preceded by an off-phase tick that must be ignored
  task automatic float_tick();
    drive(0, 0, 1);
    drive(0, 1, 1);
  endtask

  task automatic test_reset();
    drive(1, 0, 0);
    checks++;
    if (out !== 12'h000) begin errors++; $display("FAIL reset_out: got %h want 000", out); end
    checks++;
    if (noise_wb !== 8'hff) begin errors++; $display("FAIL reset_wb: got %h want ff", noise_wb); end
    drive(0, 0, 0);
  endtask

  task automatic test_directed();
    set_wave(4'b0010, 12'hABC, 1'b0, 8'h00); drive(0, 1, 0);
    checks++;
    if (out !== 12'hABC || noise_wb !== 8'hff) begin errors++; $display("FAIL saw: got %h/%h want abc/ff", out, noise_wb); end
    set_wave(4'b0010, 12'h123, 1'b0, 8'h00); drive(0, 0, 1);
    checks++;
    if (out !== 12'hABC) begin errors++; $display("FAIL no_phi2_hold: got %h want abc", out); end
    set_wave(4'b0001, 12'h801, 1'b0, 8'h00); drive(0, 1, 0);
    checks++;
    if (out !== 12'h002) begin errors++; $display("FAIL tri: got %h want 002", out); end
    set_wave(4'b0110, 12'h801, 1'b0, 8'h00); drive(0, 1, 0);
    checks++;
    if (out !== 12'h000) begin errors++; $display("FAIL pulse_saw: got %h want 000", out); end
    set_wave(4'b1010, 12'hF0F, 1'b0, 8'hAA); drive(0, 1, 0);
    checks++;
    if (out !== 12'hA00 || noise_wb !== 8'hA0) begin errors++; $display("FAIL noise_combo: got %h/%h want a00/a0", out, noise_wb); end
    set_wave(4'b1000, 12'hF0F, 1'b0, 8'hAA); drive(0, 1, 0);
    checks++;
    if (out !== 12'hAA0 || noise_wb !== 8'hff) begin errors++; $display("FAIL noise_only: got %h/%h want aa0/ff", out, noise_wb); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [3];
    vals[0] = 12'h111; vals[1] = 12'hFED; vals[2] = 12'h800;
    for (int i = 0; i < 3; i++) begin
      set_wave(4'b0010, vals[i], 1'b1, 8'h00);
      drive(0, 1, 0);
      checks++;
      if (out !== vals[i]) begin errors++; $display("FAIL b2b_%0d: got %h want %h", i, out, vals[i]); end
    end
  endtask

  task automatic test_float_6581();
    model = MOS6581;
    set_wave(4'b0010, 12'hFFF, 1'b0, 8'h00); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 53; i++) float_tick();
    checks++;
    if (out !== 12'hFFF) begin errors++; $display("FAIL f6581_hold53: got %h want fff", out); end
    float_tick();
    checks++;
    if (out !== 12'hFFF) begin errors++; $display("FAIL f6581_tick54: got %h want fff", out); end
    drive(0, 1, 0);
    float_tick();
    checks++;
    if (out !== 12'h7FF) begin errors++; $display("FAIL f6581_fade1: got %h want 7ff", out); end
    for (int i = 0; i < 12; i++) float_tick();
    checks++;
    if (out !== 12'h000) begin errors++; $display("FAIL f6581_faded: got %h want 000", out); end
  endtask

  task automatic test_float_8580();
    model = MOS8580;
    set_wave(4'b0010, 12'h555, 1'b0, 8'h00); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 799; i++) drive(0, 1, 1);
    checks++;
    if (out !== 12'h555) begin errors++; $display("FAIL f8580_hold799: got %h want 555", out); end
    drive(0, 1, 1);
    drive(0, 1, 1);
    checks++;
    if (out !== 12'h000) begin errors++; $display("FAIL f8580_fade1: got %h want 000", out); end
  endtask

  task automatic test_model_switch();
    model = MOS8580;
    set_wave(4'b0010, 12'hF0F, 1'b0, 8'h00); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 100; i++) drive(0, 1, 1);
    model = MOS6581;
    drive(0, 1, 1);
    checks++;
    if (out !== 12'hF0F) begin errors++; $display("FAIL switch_start: got %h want f0f", out); end
    drive(0, 1, 1);
    checks++;
    if (out !== 12'h707) begin errors++; $display("FAIL switch_fade: got %h want 707", out); end
  endtask

  task automatic test_reset_mid_fade();
    model = MOS6581;
    set_wave(4'b0010, 12'h7FF, 1'b0, 8'h00); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 55; i++) drive(0, 1, 1);
    checks++;
    if (out !== 12'h3FF) begin errors++; $display("FAIL midfade_pre: got %h want 3ff", out); end
    set_wave(4'b1010, 12'hFFF, 1'b0, 8'hFF); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 56; i++) drive(0, 1, 1);
    drive(1, 0, 0);
    checks++;
    if (out !== 12'h000 || noise_wb !== 8'hff) begin errors++; $display("FAIL midfade_reset: got %h/%h want 000/ff", out, noise_wb); end
    drive(0, 0, 1);
    checks++;
    if (out !== 12'h000 || noise_wb !== 8'hff) begin errors++; $display("FAIL offphase_tick: got %h/%h want 000/ff", out, noise_wb); end
    set_wave(4'b0010, 12'hFFF, 1'b0, 8'h00); drive(0, 1, 0);
    sel = 4'b0000;
    for (int i = 0; i < 54; i++) drive(0, 1, 1);
    checks++;
    if (out !== 12'hFFF) begin errors++; $display("FAIL age_cleared: got %h want fff", out); end
    drive(0, 1, 1);
    checks++;
    if (out !== 12'h7FF) begin errors++; $display("FAIL age_cleared_fade: got %h want 7ff", out); end
  endtask

  task automatic test_random();
    bit float_mode;
    drive(1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      float_mode = ((i / 1000) % 2) == 0;
      if ($urandom_range(0, 499) == 0) model = model_e'($urandom_range(0, 1));
      nz = 8'($urandom); st = 12'($urandom); pl = 1'($urandom);
      if (float_mode) sel = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'b0000;
      else sel = 4'($urandom);
      if (!float_mode && $urandom_range(0, 3) == 0) st = 12'hFFF;
      drive($urandom_range(0, 299) == 0, 1'($urandom), 1'($urandom));
      checks++;
      if (out !== m_out) begin errors++; $display("FAIL rand_out @%0d: got %h want %h", i, out, m_out); end
      checks++;
      if (noise_wb !== m_wb) begin errors++; $display("FAIL rand_wb @%0d: got %h want %h", i, noise_wb, m_wb); end
    end
  endtask

  initial begin
    model = MOS6581;
    set_wave(4'b0000, 12'h000, 1'b0, 8'h00);
    res = 1'b1; tick_ms = 1'b0; phase = '0;
    m_out = 12'h000; m_wb = 8'hff; m_ms_floating = 0; m_fading = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_float_6581();
    test_float_8580();
    test_model_switch();
    test_reset_mid_fade();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_waveform_mixer.md
# sid_waveform_mixer

Waveform selector stage for one SID voice. It consumes the raw waveform bits produced by the voice's waveform generator (saw/tri, pulse, noise, selector) and forms the 12-bit waveform DAC input. It models the floating DAC hold-and-fade that occurs when no waveform is selected, and returns the noise LFSR writeback mask for combined noise waveforms. It sits between the waveform generator and the voice DAC/envelope multiplier in `sid_voice`.

## Interface
Parameters:
- FLOAT_TTL_6581, 14'd54: ms the floating output holds before fading (6581).
- FLOAT_TTL_8580, 14'd800: ms the floating output holds before fading (8580).

Ports:
- clk  in  1  system clock; single clock domain.
- res  in  1  reset; synchronous, active-high.
- tick_ms  in  1  one-cycle strobe, once per millisecond.
- model  in  sid::model_e  MOS6581 / MOS8580.
- phase  in  sid::phase_t  one-hot SID phase strobes; state updates only on phase[sid::PHI2].
- wave  in  sid::waveform_i_t  selector[3:0] = {noise, pulse, sawtooth, triangle}, noise[7:0], pulse, saw_tri[11:0].
- out  out  12  registered waveform DAC input.
- noise_wb  out  8  registered LFSR writeback mask; LFSR bits are ANDed with it.

## Operation
- Component values, all 12 bits:
  - T = {saw_tri[10:0], 1'b0}
  - S = saw_tri
  - P = {12{pulse}}
  - N = {noise[7:0], 4'b0}
- Combined value C is the bitwise AND of the components whose selector bits are set.
- C is undefined when selector = 0. In that case the float path is used instead.
- The AND combination is the decided combined-waveform model. Lookup tables are out of scope.
- Selected (selector != 0), on PHI2:
  - out <= C.
  - age <= 0.
  - fading <= 0.
- Floating (selector == 0), on PHI2:
  - out holds its value.
  - If fading = 0 and tick_ms = 1: age increments while age != TTL, where TTL = FLOAT_TTL_6581 or FLOAT_TTL_8580 per model.
  - When age == TTL, fading <= 1 and age stops.
  - While fading = 1, each PHI2 with tick_ms = 1 applies out <= out & (out >> 1). Bits fade from LSB-adjacent runs, and out reaches 0 after at most 12 ticks.
- noise_wb, on PHI2:
  - selector[3] = 1 and |selector[2:0] = 1: noise_wb <= C[11:4].
  - Otherwise: noise_wb <= 8'hff.
- The model input may change at any time. The new TTL applies from the next comparison. If age already exceeds the new TTL, fading starts on the next PHI2 with tick_ms = 1 (comparison is age >= TTL).
- Reselecting any waveform during hold or fade immediately resumes normal output on that PHI2 and clears age and fading.

## Timing
- All state updates occur only on cycles where phase[sid::PHI2] = 1. Other cycles hold all state.
- Latency: out and noise_wb reflect the wave/selector values present on the PHI2 cycle, visible from the next clk.
- tick_ms is sampled only on PHI2 cycles. A tick not coincident with PHI2 is ignored.
- Reset (res = 1, any phase, including mid-hold or mid-fade), next clk:
  - out = 0
  - noise_wb = 8'hff
  - age = 0
  - fading = 0
- Reset takes priority over the PHI2 update.
- age is 14 bits and saturates at TTL; it never wraps.

## Test plan
- Sawtooth only: selector = 4'b0010, saw_tri = 12'hABC, PHI2 -> out = 12'hABC, noise_wb = 8'hff.
- Triangle only: selector = 4'b0001, saw_tri = 12'h801, PHI2 -> out = 12'h002. Then pulse + sawtooth: selector = 4'b0110, pulse = 0 -> out = 0.
- Combined noise: selector = 4'b1010, saw_tri = 12'hF0F, noise = 8'hAA -> out = 12'hA00, noise_wb = 8'hA0. Then selector = 4'b1000 -> noise_wb = 8'hff.
- Float 6581 with out = 12'hFFF:
  - Set selector = 0 and apply 53 PHI2-coincident tick_ms -> out = 12'hFFF.
  - 54th tick -> fading = 1, out still 12'hFFF.
  - Next tick -> 12'h7FF.
  - After 12 further ticks -> 12'h000.
- Float 8580 with out = 12'h555: 799 ticks -> out = 12'h555. After TTL, first fade tick -> 12'h000.
- Res asserted mid-fade with out = 12'h3FF -> next clk out = 0, noise_wb = 8'hff, age = 0. A tick_ms without PHI2 changes nothing.
